// File: rtl/bytecode_fetch.sv
// bytecode_fetch: Java bytecode fetch/decode stage ahead of the control unit.
// Reads opcode plus 0/1/2 argument bytes from a synchronous ROM and holds them for control.
//
// Parameter:
//   ADDR_WIDTH   ROM byte address width and pc width
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   run          fetch enable, sampled only before an opcode fetch starts
//   mem_addr/mem_rd/mem_data
//                ROM byte address, read strobe, and read data (data arrives 1 cycle after the strobe)
//   op_code/arg1/arg2
//                decoded instruction bytes, all 8'h00 outside DISPATCH
//   op_done/offset
//                control's completion pulse and signed branch displacement
//   pc           address of the current opcode byte
//   halted       set once `return` has completed
//   illegal      only present with FETCH_ILLEGAL_TRAP_EN: unsupported opcode trapped
// Optional feature: `define FETCH_ILLEGAL_TRAP_EN
module bytecode_fetch #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_data,
  output logic [7:0]            op_code,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  input  logic                  op_done,
  input  logic [15:0]           offset,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  localparam logic [2:0] S_OP_REQ  = 3'd0;
  localparam logic [2:0] S_OP_WAIT = 3'd1;
  localparam logic [2:0] S_A1_REQ  = 3'd2;
  localparam logic [2:0] S_A1_WAIT = 3'd3;
  localparam logic [2:0] S_A2_REQ  = 3'd4;
  localparam logic [2:0] S_A2_WAIT = 3'd5;
  localparam logic [2:0] S_DISP    = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            opc_q, opc_d;
  logic [7:0]            a1_q, a1_d;
  logic [7:0]            a2_q, a2_d;
  logic [1:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] off_ext;
  logic                  disp;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] l;
    unique case (1'b1)
      (op == 8'h10) || (op == 8'h12) ||
      (op == 8'h15) || (op == 8'h36):
        l = 2'd1;
      (op == 8'h11) || (op == 8'h84) ||
      ((op >= 8'h99) && (op <= 8'ha7)):
        l = 2'd2;
      default:
        l = 2'd0;
    endcase
    return l;
  endfunction

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;

  function automatic logic op_ok(input logic [7:0] op);
    return (op <= 8'h12) || (op == 8'h15) ||
           ((op >= 8'h1a) && (op <= 8'h1d)) ||
           (op == 8'h36) ||
           ((op >= 8'h3b) && (op <= 8'h3e)) ||
           ((op >= 8'h57) && (op <= 8'h59)) ||
           (op == 8'h60) || (op == 8'h64) ||
           (op == 8'h68) || (op == 8'h7e) ||
           (op == 8'h80) || (op == 8'h84) ||
           ((op >= 8'h99) && (op <= 8'ha7)) ||
           (op == 8'hb1);
  endfunction
`endif

  // Branch displacement is relative to the opcode byte.
  assign off_ext = ADDR_WIDTH'($signed(offset));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    len_d   = len_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    ill_d   = ill_q;
`endif
    unique case (state_q)
      S_OP_REQ: begin
        if (run) state_d = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        opc_d = mem_data;
        len_d = op_len(mem_data);
        a1_d  = 8'h00;
        a2_d  = 8'h00;
        state_d = (len_d == 2'd0) ? S_DISP : S_A1_REQ;
`ifdef FETCH_ILLEGAL_TRAP_EN
        if (!op_ok(mem_data)) begin
          state_d = S_HALT;
          ill_d   = 1'b1;
        end
`endif
      end
      S_A1_REQ:  state_d = S_A1_WAIT;
      S_A1_WAIT: begin
        a1_d    = mem_data;
        state_d = (len_q == 2'd2) ? S_A2_REQ : S_DISP;
      end
      S_A2_REQ:  state_d = S_A2_WAIT;
      S_A2_WAIT: begin
        a2_d    = mem_data;
        state_d = S_DISP;
      end
      S_DISP: begin
        if (op_done) begin
          if (opc_q == 8'hb1) begin
            state_d = S_HALT;
          end else begin
            state_d = S_OP_REQ;
            if (offset != 16'h0000)
              pc_d = pc_q + off_ext;
            else
              pc_d = pc_q + ADDR_WIDTH'(len_q)
                   + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP_REQ;
      pc_q    <= '0;
      opc_q   <= 8'h00;
      a1_q    <= 8'h00;
      a2_q    <= 8'h00;
      len_q   <= 2'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      ill_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      len_q   <= len_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
      ill_q   <= ill_d;
`endif
    end
  end

  // Strobe is gated by rst_n so a held-high run cannot read during reset.
  assign mem_rd = rst_n &
                  (((state_q == S_OP_REQ) & run) |
                   (state_q == S_A1_REQ) |
                   (state_q == S_A2_REQ));

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      S_OP_REQ: mem_addr = pc_q;
      S_A1_REQ: mem_addr = pc_q + ADDR_WIDTH'(1);
      S_A2_REQ: mem_addr = pc_q + ADDR_WIDTH'(2);
      default:  mem_addr = '0;
    endcase
  end

  assign disp    = (state_q == S_DISP);
  assign op_code = disp ? opc_q : 8'h00;
  assign arg1    = disp ? a1_q : 8'h00;
  assign arg2    = disp ? a2_q : 8'h00;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal = ill_q;
`endif

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb_bytecode_fetch: scoreboard bench for bytecode_fetch.
// Synchronous ROM model plus a control stub pulsing op_done.
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  op_code, arg1, arg2;
  logic        op_done = 1'b0;
  logic [15:0] offset = 16'h0000;
  logic [15:0] pc;
  logic        halted;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] pc;
    logic [15:0] off;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [7:0] rom [65536];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) mem_data <= rom[mem_addr];

  bytecode_fetch #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .op_code(op_code),
    .arg1(arg1), .arg2(arg2), .op_done(op_done),
    .offset(offset), .pc(pc), .halted(halted)
`ifdef FETCH_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  task automatic rom_clear();
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] a1,
                      input logic [7:0] a2, input logic [15:0] p,
                      input logic [15:0] off, input int lat);
    exp_t e;
    e.op = op; e.a1 = a1; e.a2 = a2;
    e.pc = p; e.off = off; e.lat = lat;
    sb.push_back(e);
  endtask

  // Leaves reset released at a negedge with run=0, DUT in OP_REQ.
  task automatic do_reset();
    run = 1'b0; op_done = 1'b0; offset = 16'h0000;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic [15:0] off);
    op_done = 1'b1;
    offset = off;
    @(negedge clk);
    op_done = 1'b0;
    offset = 16'h0000;
  endtask

  task automatic wait_disp(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (op_code !== 8'h00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_prog(input int n);
    exp_t e;
    int c;
    bit ok;
    for (int k = 0; k < n; k++) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got none, need entry");
        return;
      end
      e = sb.pop_front();
      wait_disp(c, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL disp_timeout: op %h never seen", e.op);
        return;
      end
      total += 5;
      if (op_code !== e.op) begin
        bad++;
        $display("FAIL op_code: got %h need %h", op_code, e.op);
      end
      if (arg1 !== e.a1) begin
        bad++;
        $display("FAIL arg1: got %h need %h", arg1, e.a1);
      end
      if (arg2 !== e.a2) begin
        bad++;
        $display("FAIL arg2: got %h need %h", arg2, e.a2);
      end
      if (pc !== e.pc) begin
        bad++;
        $display("FAIL pc: got %h need %h", pc, e.pc);
      end
      if (c != e.lat) begin
        bad++;
        $display("FAIL latency op %h: got %0d need %0d", e.op, c, e.lat);
      end
      repeat (2) @(negedge clk);
      total++;
      if (op_code !== e.op || mem_rd !== 1'b0) begin
        bad++;
        $display("FAIL hold: got op %h rd %b need %h 0", op_code, mem_rd, e.op);
      end
      do_op(e.off);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b1;
    #1;
    total++;
    if ({mem_rd, mem_addr, op_code, arg1, arg2, pc, halted} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got rd %b addr %h op %h pc %h h %b need all 0",
               mem_rd, mem_addr, op_code, pc, halted);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    rom_clear();
    rom[0] = 8'h02; rom[1] = 8'h05; rom[2] = 8'h05;
    rom[3] = 8'h60; rom[4] = 8'hb1;
    push(8'h02, 0, 0, 16'd0, 0, 2);
    push(8'h05, 0, 0, 16'd1, 0, 2);
    push(8'h05, 0, 0, 16'd2, 0, 2);
    push(8'h60, 0, 0, 16'd3, 0, 2);
    push(8'hb1, 0, 0, 16'd4, 0, 2);
    run = 1'b1;
    run_prog(5);
    repeat (2) @(negedge clk);
    total++;
    if (halted !== 1'b1 || pc !== 16'd4 || op_code !== 8'h00 || mem_rd !== 1'b0) begin
      bad++;
      $display("FAIL basic_halt: got h %b pc %h op %h rd %b need 1 0004 00 0",
               halted, pc, op_code, mem_rd);
    end
  endtask

  task automatic test_lengths();
    do_reset();
    rom_clear();
    rom[0] = 8'h10; rom[1] = 8'h7f; rom[2] = 8'h11;
    rom[3] = 8'h12; rom[4] = 8'h34; rom[5] = 8'hb1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    push(8'h10, 8'h7f, 8'h00, 16'd0, 0, 3);
    run_prog(1);
    repeat (3) @(negedge clk);
    do_op(16'h0005);
    total++;
    if (pc !== 16'd2 || mem_rd !== 1'b0 || op_code !== 8'h00) begin
      bad++;
      $display("FAIL stall: got pc %h rd %b op %h need 0002 0 00",
               pc, mem_rd, op_code);
    end
    run = 1'b1;
    push(8'h11, 8'h12, 8'h34, 16'd2, 0, 6);
    push(8'hb1, 8'h00, 8'h00, 16'd5, 0, 2);
    run_prog(2);
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || pc !== 16'd5) begin
      bad++;
      $display("FAIL len_end: got h %b pc %h need 1 0005", halted, pc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    rom_clear();
    rom[0] = 8'ha7; rom[1] = 8'h00; rom[2] = 8'h08;
    rom[4] = 8'ha7; rom[5] = 8'h00; rom[6] = 8'h04;
    rom[8] = 8'h99; rom[9] = 8'hff; rom[10] = 8'hfc;
    rom[11] = 8'hb1;
    push(8'ha7, 8'h00, 8'h08, 16'd0, 16'h0008, 6);
    push(8'h99, 8'hff, 8'hfc, 16'd8, 16'hfffc, 6);
    push(8'ha7, 8'h00, 8'h04, 16'd4, 16'h0004, 6);
    push(8'h99, 8'hff, 8'hfc, 16'd8, 16'h0000, 6);
    push(8'hb1, 8'h00, 8'h00, 16'd11, 16'h0000, 2);
    run = 1'b1;
    run_prog(5);
    @(negedge clk);
    total++;
    if (halted !== 1'b1 || pc !== 16'd11) begin
      bad++;
      $display("FAIL br_end: got h %b pc %h need 1 000b", halted, pc);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b0 || op_code !== 8'h00 || pc !== 16'd0) begin
        bad++;
        $display("FAIL idle%0d: got rd %b op %h pc %h need 0 00 0000",
                 i, mem_rd, op_code, pc);
      end
    end
    run = 1'b1;
    #1;
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'd0) begin
      bad++;
      $display("FAIL idle_go: got rd %b addr %h need 1 0000", mem_rd, mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rom_clear();
    rom[0] = 8'h10; rom[1] = 8'h7f; rom[2] = 8'hb1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_rd, mem_addr, op_code, arg1, arg2, pc, halted} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got rd %b addr %h op %h a1 %h pc %h need 0",
               mem_rd, mem_addr, op_code, arg1, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h10, 8'h7f, 8'h00, 16'd0, 0, 4);
    push(8'hb1, 8'h00, 8'h00, 16'd2, 0, 2);
    run_prog(2);
  endtask

`ifdef FETCH_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    do_reset();
    rom_clear();
    rom[0] = 8'h02; rom[1] = 8'hff;
    run = 1'b1;
    push(8'h02, 0, 0, 16'd0, 0, 2);
    run_prog(1);
    repeat (4) @(negedge clk);
    total++;
    if (illegal !== 1'b1 || halted !== 1'b1 || pc !== 16'd1 || op_code !== 8'h00) begin
      bad++;
      $display("FAIL illegal: got i %b h %b pc %h op %h need 1 1 0001 00",
               illegal, halted, pc, op_code);
    end
  endtask
`endif

  initial begin
    rom_clear();
    test_reset();
    test_basic();
    test_lengths();
    test_branch();
    test_idle();
    test_reset_mid();
`ifdef FETCH_ILLEGAL_TRAP_EN
    test_illegal();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
